uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (115200 baud at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame; legal range 5..9.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset: asynchronous, active-low.
REQ-005 SHALL have port tx_valid  input  1  requester has a byte to send.
REQ-006 SHALL have port tx_data  input  DATA_BITS  payload; sampled only on accept.
REQ-007 SHALL have port tx_ready  output  1  controller can accept a payload this cycle.
REQ-008 SHALL have port tx  output  1  serial line; idle high.
REQ-009 SHALL have port busy  output  1  frame in progress (any state other than IDLE).
REQ-010 SHALL have port done  output  1  one-cycle pulse on frame completion.

Function
REQ-011 SHALL implement states IDLE, START, DATA, STOP; PARITY is added only per REQ-027.
REQ-012 SHALL assert tx_ready only in IDLE; accept occurs on a cycle with tx_valid=1 and tx_ready=1.
REQ-013 SHALL, on accept, capture tx_data into an internal shift register, enter START, and drive tx=0 from the next cycle; later changes to tx_data SHALL NOT affect the frame.
REQ-014 SHALL hold tx_valid=1 while tx_ready=0 without effect; no accept or queuing.
REQ-015 SHALL time each bit with an internal counter of width $clog2(CLKS_PER_BIT): it counts 0..CLKS_PER_BIT-1, wraps to 0, and the wrap cycle ends the current bit.
REQ-016 SHALL hold every bit, including start and stop, on tx for exactly CLKS_PER_BIT cycles.
REQ-017 SHALL transmit data LSB first in DATA, using a bit index 0..DATA_BITS-1, and leave DATA on the wrap of bit DATA_BITS-1.
REQ-018 SHALL drive tx=1 in STOP and return to IDLE on the stop-bit wrap; done=1 for exactly that transition cycle.
REQ-019 SHALL register tx, so it is glitch-free; tx=1 in IDLE.
REQ-020 SHALL allow back-to-back frames: with tx_valid held high, a new accept occurs on the first IDLE cycle. Start-of-frame spacing is 1 + CLKS_PER_BIT*(DATA_BITS+2) cycles, plus CLKS_PER_BIT when parity is enabled.
REQ-021 SHALL drive busy=1 from the cycle after accept through the last stop-bit cycle.

Reset
REQ-022 SHALL, while rst=0, force state=IDLE, tx=1, tx_ready=0, busy=0, done=0, bit counter=0, bit index=0, shift register=0, immediately and independent of clk.
REQ-023 SHALL drive tx_ready=1 from the first rising clk edge after rst returns to 1.
REQ-024 SHALL, when reset is asserted mid-frame, abandon the frame: tx returns high asynchronously, no done pulse is produced, and no residual frame is resumed after reset.

Configuration
REQ-025 SHALL use macro UART_TX_PARITY_EN to compile the parity feature in or out.
REQ-026 SHALL, without UART_TX_PARITY_EN, send the frame start + DATA_BITS + stop and contain no parity logic.
REQ-027 SHALL, with UART_TX_PARITY_EN, insert a PARITY state between DATA and STOP. That state drives the even-parity bit (XOR of the captured payload) for CLKS_PER_BIT cycles.

Verification
REQ-028 SHALL verify a single frame with CLKS_PER_BIT=4, tx_data=8'hA5: tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; done pulses once, 41 cycles after accept.
REQ-029 SHALL verify back-to-back frames with tx_valid held high for 8'h00 then 8'hFF: second accept on the first IDLE cycle after done; no idle-high gap beyond 1 cycle.
REQ-030 SHALL verify ignored input: tx_data changed from 8'h3C to 8'hC3 one cycle after accept, with tx_valid toggled during busy: serial output is 8'h3C and exactly one frame is sent.
REQ-031 SHALL verify reset mid-frame: rst=0 during DATA bit 3 gives tx=1 and tx_ready=0 within the same cycle, no done; after release, tx_ready=1 on the next edge and a new frame with 8'h81 is sent intact.
REQ-032 SHALL verify parity with UART_TX_PARITY_EN defined: 8'h07 gives parity bit 1 and 8'h03 gives parity bit 0, each held 4 cycles before the stop bit; frame length is 44 cycles.
REQ-033 SHALL verify a boundary case with CLKS_PER_BIT=2 and DATA_BITS=5: the 5'h15 frame has every bit exactly 2 cycles and the bit counter wraps correctly.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start + DATA_BITS (LSB first) + stop, with registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_ctrl #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;
`endif

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 tx_q, tx_d;
   logic                 tx_ready_q, tx_ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 bit_end;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif

   assign bit_end = (cnt_q == CNT_MAX);

   // tx_d always carries the level of the bit that starts after this edge, so tx stays a pure flop
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shreg_d    = shreg_q;
      tx_d       = tx_q;
      tx_ready_d = tx_ready_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d      = par_q;
`endif
      if (state_q != ST_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
         ST_IDLE: begin
            tx_d       = 1'b1;
            tx_ready_d = 1'b1;
            busy_d     = 1'b0;
            cnt_d      = '0;
            idx_d      = '0;
            if (tx_valid && tx_ready_q) begin
               shreg_d    = tx_data;
               state_d    = ST_START;
               tx_d       = 1'b0;
               tx_ready_d = 1'b0;
               busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
               par_d      = ^tx_data;
`endif
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               tx_d    = shreg_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (idx_q == IDX_MAX) begin
                  idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  tx_d    = par_q;
`else
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  idx_d   = idx_q + 1'b1;
                  shreg_d = shreg_q >> 1;
                  tx_d    = shreg_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               state_d    = ST_IDLE;
               tx_d       = 1'b1;
               tx_ready_d = 1'b1;
               busy_d     = 1'b0;
               done_d     = 1'b1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            tx_d       = 1'b1;
            tx_ready_d = 1'b0;
            busy_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shreg_q    <= '0;
         tx_q       <= 1'b1;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shreg_q    <= shreg_d;
         tx_q       <= tx_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   assign tx       = tx_q;
   assign tx_ready = tx_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: 4-clock/8-bit instance plus a 2-clock/5-bit boundary instance.
// Status vectors compared per cycle are {busy, done, tx_ready, tx}.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int CPB  = 4;
   localparam int NB   = 10 + PAR;
   localparam int CPB2 = 2;
   localparam int NB2  = 7 + PAR;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_ready, tx, busy, done;
   logic       tx_valid2 = 1'b0;
   logic [4:0] tx_data2 = '0;
   logic       tx_ready2, tx2, busy2, done2;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .tx(tx), .busy(busy), .done(done));

   uart_tx_ctrl #(.CLKS_PER_BIT(CPB2), .DATA_BITS(5)) dut2 (
      .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_data(tx_data2),
      .tx_ready(tx_ready2), .tx(tx2), .busy(busy2), .done(done2));

   typedef struct {
      logic [7:0] data;
      logic [7:0] lsb_first;  // bit 7 is the first data bit on the wire
      logic       par;
      bit         toggle;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string name);
      for (int i = 0; i < 500; i++) begin
         if (tx_ready === 1'b1) break;
         @(negedge clk);
      end
      chk({name, " ready"}, {3'b000, tx_ready}, 4'b0001);
   endtask

   // Called just after the accept edge; returns at the negedge of the done cycle.
   task automatic check_frame(input string name, input logic [7:0] bits, input logic par,
                              input bit toggle);
      for (int k = 0; k < NB; k++) begin
         logic e;
         if (k == 0) e = 1'b0;
         else if (k <= 8) e = bits[8-k];
         else if (k == NB - 1) e = 1'b1;
         else e = par;
         for (int c = 0; c < CPB; c++) begin
            int i;
            i = k * CPB + c;
            @(negedge clk);
            chk($sformatf("%s bit%0d cyc%0d", name, k, c), {busy, done, tx_ready, tx}, {3'b100, e});
            if (toggle) tx_valid = (i < NB * CPB - 1) ? i[0] : 1'b0;
         end
      end
      @(negedge clk);
      chk({name, " done"}, {busy, done, tx_ready, tx}, 4'b0111);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{8'hA5, 8'b10100101, 1'b0, 1'b0};
      tbl[1] = '{8'h3C, 8'b00111100, 1'b0, 1'b1};
      tbl[2] = '{8'h07, 8'b11100000, 1'b1, 1'b0};
      tbl[3] = '{8'h03, 8'b11000000, 1'b0, 1'b0};
      tbl[4] = '{8'h4E, 8'b01110010, 1'b0, 1'b0};
      tbl[5] = '{8'h01, 8'b10000000, 1'b1, 1'b1};

      #1 rst = 1'b0;
      #2;
      chk("reset dut", {busy, done, tx_ready, tx}, 4'b0001);
      chk("reset dut2", {busy2, done2, tx_ready2, tx2}, 4'b0001);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1 chk("pre-edge ready", {busy, done, tx_ready, tx}, 4'b0001);
      @(posedge clk);
      #1 chk("ready after reset", {busy, done, tx_ready, tx}, 4'b0011);

      // table: single frames, payload changed after accept, valid toggled while busy
      for (int v = 0; v < 6; v++) begin
         wait_ready($sformatf("vec%0d", v));
         tx_valid = 1'b1;
         tx_data  = tbl[v].data;
         @(posedge clk);
         #1;
         tx_valid = 1'b0;
         tx_data  = ~tbl[v].data;
         check_frame($sformatf("vec%0d", v), tbl[v].lsb_first, tbl[v].par, tbl[v].toggle);
      end
      @(negedge clk);
      chk("single frame only", {busy, done, tx_ready, tx}, 4'b0011);

      // back-to-back with tx_valid held high
      wait_ready("b2b");
      tx_valid = 1'b1;
      tx_data  = 8'h00;
      @(posedge clk);
      #1 tx_data = 8'hFF;
      check_frame("b2b0", 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      check_frame("b2b1", 8'hFF, 1'b0, 1'b0);

      // reset during data bit 3 (cycle 18 of the frame)
      wait_ready("rst");
      tx_valid = 1'b1;
      tx_data  = 8'hF0;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      repeat (18) @(negedge clk);
      chk("bit3 before reset", {busy, done, tx_ready, tx}, 4'b1000);
      #1 rst = 1'b0;
      #1 chk("async reset", {busy, done, tx_ready, tx}, 4'b0001);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("in reset %0d", i), {busy, done, tx_ready, tx}, 4'b0001);
      end
      rst = 1'b1;
      @(posedge clk);
      #1 chk("ready after mid reset", {busy, done, tx_ready, tx}, 4'b0011);
      tx_valid = 1'b1;
      tx_data  = 8'h81;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      check_frame("after reset 81", 8'b10000001, 1'b0, 1'b0);

      // boundary instance: 2 clocks per bit, 5 data bits, payload 5'h15
      for (int i = 0; i < 500; i++) begin
         if (tx_ready2 === 1'b1) break;
         @(negedge clk);
      end
      chk("dut2 ready", {busy2, done2, tx_ready2, tx2}, 4'b0011);
      tx_valid2 = 1'b1;
      tx_data2  = 5'h15;
      @(posedge clk);
      #1;
      tx_valid2 = 1'b0;
      tx_data2  = 5'h0A;
      begin
         logic [4:0] bits2;
         bits2 = 5'b10101;
         for (int k = 0; k < NB2; k++) begin
            logic e;
            if (k == 0) e = 1'b0;
            else if (k <= 5) e = bits2[5-k];
            else if (k == NB2 - 1) e = 1'b1;
            else e = 1'b1;  // parity of 5'h15 (three ones)
            for (int c = 0; c < CPB2; c++) begin
               @(negedge clk);
               chk($sformatf("dut2 bit%0d cyc%0d", k, c), {busy2, done2, tx_ready2, tx2}, {3'b100, e});
            end
         end
      end
      @(negedge clk);
      chk("dut2 done", {busy2, done2, tx_ready2, tx2}, 4'b0111);
      @(negedge clk);
      chk("dut2 idle", {busy2, done2, tx_ready2, tx2}, 4'b0011);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
